// File: rtl/bird_motion_pkg.sv
// Shared game geometry and bird physics constants. The collision detector and
// renderer import the same package, so every block agrees on the coordinate
// width, the start position and the floor line.
package bird_motion_pkg;

  localparam int COORD_W = 10;
  localparam int VEL_W   = 5;
  localparam int SUM_W   = 11;

  localparam logic [COORD_W-1:0] Y_START  = 10'd232;
  localparam logic [COORD_W-1:0] GROUND_Y = 10'd448;
  localparam logic [COORD_W-1:0] BIRD_H   = 10'd16;
  localparam logic [COORD_W-1:0] Y_FLOOR  = GROUND_Y - BIRD_H;

  localparam logic signed [VEL_W-1:0] FLAP_VEL = -5'sd8;
  localparam logic signed [VEL_W-1:0] GRAVITY  = 5'sd1;
  localparam logic signed [VEL_W-1:0] VMAX     = 5'sd8;

  // One frame of gravity with terminal-velocity saturation. The largest input
  // is VMAX, so the intermediate sum still fits the 5-bit signed range.
  function automatic logic signed [VEL_W-1:0] applyGravity(
    input logic signed [VEL_W-1:0] v
  );
    logic signed [VEL_W-1:0] s;
    s = v + GRAVITY;
    return (s > VMAX) ? VMAX : s;
  endfunction

endpackage

// File: rtl/bird_vel.sv
// Bird vertical velocity register. The top decides when a frame step is
// applied and whether a flap overrides the stored velocity; this block
// supplies the velocity used for the current step and keeps the next one.
module bird_vel
  import bird_motion_pkg::*;
(
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iClear,
  input  logic                    iApply,
  input  logic                    iFlap,
  output logic signed [VEL_W-1:0] oStepVel
);

  logic signed [VEL_W-1:0] vel;

  assign oStepVel = iFlap ? FLAP_VEL : vel;

  // Velocity for the next frame: zeroed when the bird is parked, otherwise
  // the step velocity plus gravity, capped at terminal velocity.
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      vel <= '0;
    end else if (iApply) begin
      vel <= applyGravity(oStepVel);
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird position and life-cycle controller. Tracks the bird's top edge per
// frame, clamps it at the ceiling, kills it on the floor, and switches to a
// flap-less fall after a pipe hit.
module bird_motion
  import bird_motion_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iBirdRst,
  input  logic               iBirdWait,
  input  logic               iFlapPressed,
  input  logic               iFrameTick,
  input  logic               iPipeHit,
  output logic [COORD_W-1:0] oBirdY,
  output logic               oBirdDead
);

  typedef enum logic [1:0] {
    S_READY,
    S_FLY,
    S_FALL,
    S_DEAD
  } stateT;

  stateT                    state;
  logic                     flapPending;
  logic                     rstAll;
  logic                     applyTick;
  logic                     useFlap;
  logic                     velClear;
  logic signed [VEL_W-1:0]  stepVel;
  logic signed [SUM_W-1:0]  ySum;
  logic [COORD_W-1:0]       yNext;
  logic                     hitGround;

  assign rstAll    = iRst | iBirdRst;
  assign applyTick = iFrameTick &
                     (((state == S_FLY) & ~iBirdWait) | (state == S_FALL));
  assign useFlap   = (state == S_FLY) & (flapPending | iFlapPressed);
  assign velClear  = (state == S_READY) | (state == S_DEAD) |
                     (applyTick & hitGround);

  bird_vel uVel (
    .iClk     (iClk),
    .iRst     (rstAll),
    .iClear   (velClear),
    .iApply   (applyTick),
    .iFlap    (useFlap),
    .oStepVel (stepVel)
  );

  // Candidate position for this frame, widened so a climb past the top of
  // the screen shows up as a negative value that is clamped to zero.
  always_comb begin
    ySum      = $signed({1'b0, oBirdY}) +
                $signed({{(SUM_W-VEL_W){stepVel[VEL_W-1]}}, stepVel});
    yNext     = ySum[COORD_W-1:0];
    hitGround = 1'b0;
    if (ySum < 0) begin
      yNext = '0;
    end else if (ySum >= $signed({1'b0, Y_FLOOR})) begin
      yNext     = Y_FLOOR;
      hitGround = 1'b1;
    end
  end

  // Bird life cycle, position and pending flap. Either reset source wins over
  // every other input; a floor contact outranks a simultaneous pipe hit.
  always_ff @(posedge iClk) begin
    if (rstAll) begin
      state       <= S_READY;
      oBirdY      <= Y_START;
      flapPending <= 1'b0;
      oBirdDead   <= 1'b0;
    end else begin
      case (state)
        S_READY: begin
          oBirdY      <= Y_START;
          flapPending <= 1'b0;
          if (!iBirdWait) begin
            state <= S_FLY;
          end
        end
        S_FLY: begin
          if (applyTick) begin
            oBirdY      <= yNext;
            flapPending <= 1'b0;
            if (hitGround) begin
              state     <= S_DEAD;
              oBirdDead <= 1'b1;
            end else if (iPipeHit) begin
              state     <= S_FALL;
              oBirdDead <= 1'b1;
            end
          end else begin
            if (iBirdWait) begin
              flapPending <= 1'b0;
            end else if (iFlapPressed) begin
              flapPending <= 1'b1;
            end
            if (iPipeHit) begin
              state     <= S_FALL;
              oBirdDead <= 1'b1;
            end
          end
        end
        S_FALL: begin
          flapPending <= 1'b0;
          if (applyTick) begin
            oBirdY <= yNext;
            if (hitGround) begin
              state <= S_DEAD;
            end
          end
        end
        S_DEAD: begin
          oBirdY      <= Y_FLOOR;
          flapPending <= 1'b0;
          oBirdDead   <= 1'b1;
        end
        default: begin
          state <= S_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: integer flight model checked every cycle,
// plus hand-worked position checkpoints along the stimulus sequence.
module tb_bird_motion;

  localparam int M_READY = 0;
  localparam int M_FLY   = 1;
  localparam int M_FALL  = 2;
  localparam int M_DEAD  = 3;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iBirdRst = 1'b0;
  logic       iBirdWait = 1'b1;
  logic       iFlapPressed = 1'b0;
  logic       iFrameTick = 1'b0;
  logic       iPipeHit = 1'b0;
  logic [9:0] oBirdY;
  logic       oBirdDead;

  int  vecCount = 0;
  int  failCount = 0;
  bit  checkEn = 1'b0;

  int  mY = 232;
  int  mVel = 0;
  bit  mPend = 1'b0;
  int  mMode = M_READY;
  bit  mDead;

  bird_motion dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iBirdRst     (iBirdRst),
    .iBirdWait    (iBirdWait),
    .iFlapPressed (iFlapPressed),
    .iFrameTick   (iFrameTick),
    .iPipeHit     (iPipeHit),
    .oBirdY       (oBirdY),
    .oBirdDead    (oBirdDead)
  );

  always #5 iClk = ~iClk;

  assign mDead = (mMode == M_FALL) || (mMode == M_DEAD);

  // Physics model in plain integers: one frame moves the bird by its
  // velocity, then gravity adds one up to a terminal speed of 8.
  always @(posedge iClk) begin
    int v;
    int t;
    if (iRst || iBirdRst) begin
      mMode = M_READY; mY = 232; mVel = 0; mPend = 1'b0;
    end else begin
      case (mMode)
        M_READY: begin
          mPend = 1'b0;
          if (!iBirdWait) mMode = M_FLY;
        end
        M_FLY: begin
          if (iFrameTick && !iBirdWait) begin
            v = (mPend || iFlapPressed) ? -8 : mVel;
            mPend = 1'b0;
            t = mY + v;
            if (t >= 432) begin
              mY = 432; mVel = 0; mMode = M_DEAD;
            end else begin
              mY = (t < 0) ? 0 : t;
              mVel = (v + 1 > 8) ? 8 : v + 1;
              if (iPipeHit) mMode = M_FALL;
            end
          end else begin
            if (iBirdWait) mPend = 1'b0;
            else if (iFlapPressed) mPend = 1'b1;
            if (iPipeHit) mMode = M_FALL;
          end
        end
        M_FALL: begin
          mPend = 1'b0;
          if (iFrameTick) begin
            t = mY + mVel;
            if (t >= 432) begin
              mY = 432; mVel = 0; mMode = M_DEAD;
            end else begin
              mY = (t < 0) ? 0 : t;
              mVel = (mVel + 1 > 8) ? 8 : mVel + 1;
            end
          end
        end
        default: begin
          mY = 432; mVel = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge iClk) begin
    if (checkEn) begin
      vecCount = vecCount + 2;
      if (oBirdY !== 10'(mY)) begin
        failCount++;
        $display("[TB] FAIL model_y t=%0t got %0d want %0d", $time, oBirdY, mY);
      end
      if (oBirdDead !== mDead) begin
        failCount++;
        $display("[TB] FAIL model_dead t=%0t got %0b want %0b", $time, oBirdDead, mDead);
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit brst, input bit wt,
                               input bit tk, input bit fl, input bit ht);
    @(negedge iClk);
    iRst = rst; iBirdRst = brst; iBirdWait = wt;
    iFrameTick = tk; iFlapPressed = fl; iPipeHit = ht;
    @(posedge iClk);
    #1;
    iRst = 1'b0; iBirdRst = 1'b0; iFrameTick = 1'b0;
    iFlapPressed = 1'b0; iPipeHit = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int expY, input bit expDead);
    vecCount = vecCount + 4;
    if (oBirdY !== 10'(expY)) begin
      failCount++;
      $display("[TB] FAIL %s dut_y got %0d want %0d", name, oBirdY, expY);
    end
    if (oBirdDead !== expDead) begin
      failCount++;
      $display("[TB] FAIL %s dut_dead got %0b want %0b", name, oBirdDead, expDead);
    end
    if (mY != expY) begin
      failCount++;
      $display("[TB] FAIL %s model_y got %0d want %0d", name, mY, expY);
    end
    if (mDead != expDead) begin
      failCount++;
      $display("[TB] FAIL %s model_dead got %0b want %0b", name, mDead, expDead);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkEn = 1'b1;
    checkOutput("reset", 232, 0);

    // Free fall from the start position with no flaps.
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      if (i == 1)  checkOutput("fall_tick1", 232, 0);
      if (i == 3)  checkOutput("fall_tick3", 235, 0);
      if (i == 29) checkOutput("fall_tick29", 428, 0);
      if (i == 30) checkOutput("fall_ground", 432, 1);
    end
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("dead_hold", 432, 1);

    // Bird reset beats a simultaneous tick, flap and hit.
    applyStimulus(0, 1, 0, 1, 1, 1);
    checkOutput("birdrst_override", 232, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("vel3", 235, 0);

    // Flap latched ahead of the tick, then the follow-on frame.
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("flap_pending_nomove", 235, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("flap_applied", 227, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("after_flap", 220, 0);

    // Climb to the ceiling and clamp.
    for (int i = 0; i < 27; i++) applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("near_ceiling", 4, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("ceiling_clamp", 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("ceiling_hold", 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("leave_ceiling", 3, 0);

    // Pause: flap dropped, ticks frozen.
    applyStimulus(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("wait_frozen", 3, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait_flap_dropped", 6, 0);

    // Pipe hit, flap-less fall through a pause, then bird reset.
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pipe_hit", 6, 1);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput("fall_ignores_flap", 10, 1);
    for (int i = 0; i < 60; i++) applyStimulus(0, 0, 1, 1, i[0], 0);
    checkOutput("fall_to_floor", 432, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("birdrst_after_fall", 232, 0);

    // System reset mid-fall leaves no residual velocity.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("midfall", 242, 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("rst_midfall", 232, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("no_residual_vel", 232, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("restart_motion", 233, 0);

    @(negedge iClk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 SHALL have port iClk, input, 1 bit: system clock, all logic on rising edge.
REQ-002 SHALL have port iRst, input, 1 bit: reset, synchronous, active-high; one clock; no other clock or reset domain.
REQ-003 SHALL have port iBirdRst, input, 1 bit: bird reset from game FSM; held high while game is in INIT.
REQ-004 SHALL have port iBirdWait, input, 1 bit: freeze request from game FSM; high while paused.
REQ-005 SHALL have port iFlapPressed, input, 1 bit: one-cycle debounced flap pulse.
REQ-006 SHALL have port iFrameTick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-007 SHALL have port iPipeHit, input, 1 bit: level from collision detector; bird overlaps a pipe.
REQ-008 SHALL have port oBirdY, output, 10 bits: bird top edge, unsigned pixels, 0 = screen top.
REQ-009 SHALL have port oBirdDead, output, 1 bit: registered; feeds game FSM iBirdDead.
REQ-010 SHALL have parameters Y_START=232, GROUND_Y=448, BIRD_H=16, FLAP_VEL=-8, GRAVITY=1, VMAX=8; floor position Y_FLOOR = GROUND_Y-BIRD_H = 432.

Function
REQ-011 SHALL use states S_READY, S_FLY, S_FALL, S_DEAD.
REQ-012 SHALL hold velocity as signed 5-bit; SHALL compute Y updates in 11-bit signed to detect underflow.
REQ-013 S_READY: Y=Y_START, vel=0, flap flag clear; SHALL go to S_FLY on the first cycle with iBirdWait low; no position update that cycle.
REQ-014 SHALL latch iFlapPressed into a pending-flap flag in S_FLY; flag cleared on each applied tick.
REQ-015 S_FLY, on iFrameTick with iBirdWait low: v = FLAP_VEL if flap pending or iFlapPressed this cycle, else vel; Y <= Y+v; vel <= min(v+GRAVITY, VMAX).
REQ-016 Ceiling: if Y+v < 0, Y SHALL be 0; not fatal; velocity update unchanged.
REQ-017 Ground: if Y+v >= Y_FLOOR, Y SHALL be Y_FLOOR and state SHALL go to S_DEAD.
REQ-018 iPipeHit high in S_FLY, any cycle, SHALL go to S_FALL; if the same tick also reaches ground, S_DEAD wins.
REQ-019 S_FALL: flaps ignored and flag cleared; on each iFrameTick, gravity update per REQ-015 without flap, regardless of iBirdWait; S_DEAD on reaching Y_FLOOR.
REQ-020 S_DEAD: Y held at Y_FLOOR, vel=0; leaves only via iBirdRst or iRst.
REQ-021 iBirdWait high in S_FLY SHALL freeze Y, vel and state, and SHALL clear the pending flag; flaps while waiting SHALL be dropped.
REQ-022 oBirdDead SHALL be high exactly in S_FALL and S_DEAD, asserting one cycle after the hit/ground event.
REQ-023 oBirdY SHALL update one cycle after the accepted iFrameTick; stable otherwise.
REQ-024 iBirdRst SHALL act identically to iRst, overriding all inputs including simultaneous tick, flap or hit.

Reset
REQ-025 On iRst or iBirdRst: state=S_READY, oBirdY=232, vel=0, pending flap=0, oBirdDead=0, effective next cycle.
REQ-026 Reset mid-fall or mid-flap SHALL discard all motion state; no residual velocity.

Structure
REQ-027 Y_START, GROUND_Y, BIRD_H, FLAP_VEL, GRAVITY, VMAX and the 10-bit coordinate width SHALL live in the shared game parameter include, also used by the collision and renderer blocks.
REQ-028 State encodings SHALL be local to this module.
REQ-029 One sub-module, bird_vel: velocity register with flap load, gravity add and VMAX saturation; position and FSM in bird_motion.

Verification
REQ-030 Reset, iBirdWait low, 30 ticks, no flaps -> Y: 232,232,233,235,...; Y=428 after tick 29; Y=432 and oBirdDead=1 one cycle after tick 30.
REQ-031 S_FLY at Y=100, vel=3, flap pulse then tick -> Y=92, vel=-7; next tick -> Y=85, vel=-6.
REQ-032 Y=4, flap with tick in same cycle -> Y=0, vel=-7, oBirdDead=0.
REQ-033 iBirdWait high, flap pulse, 5 ticks -> Y and vel unchanged; wait low, tick -> no flap applied.
REQ-034 iPipeHit at Y=200 -> oBirdDead=1 next cycle; flaps ignored; falls to Y=432 despite iBirdWait=1; iBirdRst -> Y=232, oBirdDead=0.
